uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 82 ++++++++
 rtl/uart_rx_fifo.sv | 194 +++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg -- encodings shared by the UART receiver and the future transmitter.
//   PARITY_*   : parity-mode encodings for the PARITY parameter
//   ST_*       : frame FSM state encodings
//   parity_mismatch() : true when a received parity bit disagrees with the data
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_BREAK = 3'd5;

  // Data narrower than 8 bits is zero-extended by the caller; zeros do not
  // change the XOR reduction.
  function automatic logic parity_mismatch(input logic [7:0] data,
                                           input logic       par_bit,
                                           input int         mode);
    logic ones_odd;
    ones_odd = ^data;
    case (mode)
      PARITY_ODD:  return ~(ones_odd ^ par_bit);
      PARITY_EVEN: return ones_odd ^ par_bit;
      default:     return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo -- single-clock first-word-fall-through FIFO.
//   clk, rst  : clock, synchronous active-high reset
//   wr_en     : push request; dropped (overrun pulse) when full and no pop
//   wr_data   : word to push
//   rd_en     : pop request; ignored when empty
//   rd_data   : current head word (don't-care while empty)
//   empty/full: occupancy flags
//   count     : number of stored words
//   overrun   : one-cycle pulse when a push is dropped
// -----------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overrun
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             rd_fire, wr_fire;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a push into a full FIFO
  // still lands when it is paired with a pop.
  assign rd_fire = rd_en & ~empty;
  assign wr_fire = wr_en & (~full | rd_fire);
  assign overrun = wr_en & ~wr_fire;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned and a latch is never inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_fire) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are valid, so clearing the array would only cost logic.
  always_ff @(posedge clk) begin
    if (wr_fire && !rst) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo -- UART receiver feeding a receive FIFO, with sticky errors.
//   CLK, RST         : clock, synchronous active-high reset
//   RXD              : asynchronous serial line, idle high
//   RD_EN            : pop the FIFO head
//   RD_DATA          : FIFO head (first-word-fall-through)
//   EMPTY/FULL/COUNT : FIFO occupancy
//   ERR_CLR          : clears the sticky error flags
//   FRAME_ERR        : stop bit sampled low
//   PARITY_ERR       : parity bit disagreed with the data
//   OVERRUN          : a good frame arrived while the FIFO was full
// -----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          RXD,
  input  logic                          RD_EN,
  output logic [DATA_BITS-1:0]          RD_DATA,
  output logic                          EMPTY,
  output logic                          FULL,
  output logic [$clog2(FIFO_DEPTH):0]   COUNT,
  input  logic                          ERR_CLR,
  output logic                          FRAME_ERR,
  output logic                          PARITY_ERR,
  output logic                          OVERRUN
);

  localparam logic [15:0] HALF_BIT = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] FULL_BIT = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  logic                 sync1_q, sync1_d, sync2_q, sync2_d;
  logic [1:0]           valid_q, valid_d;
  logic                 prev_high_q, prev_high_d;
  logic [2:0]           state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 overrun_q, overrun_d;

  logic rx_s;
  logic cnt_done;
  logic push;
  logic frame_evt, parity_evt, overrun_evt;

  assign rx_s     = sync2_q;
  assign cnt_done = (cnt_q == '0);

  always_comb begin
    sync1_d = RXD;
    sync2_d = sync1_q;
    // The synchronizer resets to "idle high"; valid_q marks when sync2_q holds
    // a real line sample, so a line held low across reset is not mistaken
    // for a fresh start edge.
    valid_d     = {valid_q[0], 1'b1};
    prev_high_d = valid_q[1] & rx_s;

    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    par_bad_d  = par_bad_q;
    push       = 1'b0;
    frame_evt  = 1'b0;
    parity_evt = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (valid_q[1] && prev_high_q && !rx_s) begin
          state_d   = ST_START;
          cnt_d     = HALF_BIT;
          par_bad_d = 1'b0;
        end
      end
      ST_START: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - 1'b1;
        end else if (!rx_s) begin
          state_d   = ST_DATA;
          cnt_d     = FULL_BIT;
          bit_idx_d = '0;
        end else begin
          state_d = ST_IDLE;           // glitch shorter than half a bit
        end
      end
      ST_DATA: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};   // LSB arrives first
          cnt_d   = FULL_BIT;
          if (bit_idx_q == LAST_BIT) begin
            state_d = (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      ST_PAR: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          par_bad_d = parity_mismatch(8'(shift_q), rx_s, PARITY);
          state_d   = ST_STOP;
          cnt_d     = FULL_BIT;
        end
      end
      ST_STOP: begin
        if (!cnt_done) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          parity_evt = par_bad_q;
          if (rx_s) begin
            push    = ~par_bad_q;
            state_d = ST_IDLE;
          end else begin
            frame_evt = 1'b1;
            state_d   = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A new error event in the same cycle as ERR_CLR keeps the flag set.
    frame_err_d  = frame_evt   | (frame_err_q  & ~ERR_CLR);
    parity_err_d = parity_evt  | (parity_err_q & ~ERR_CLR);
    overrun_d    = overrun_evt | (overrun_q    & ~ERR_CLR);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      valid_q      <= '0;
      prev_high_q  <= 1'b0;
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      par_bad_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      valid_q      <= valid_d;
      prev_high_q  <= prev_high_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      par_bad_q    <= par_bad_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
    end
  end

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (push),
    .wr_data (shift_q),
    .rd_en   (RD_EN),
    .rd_data (RD_DATA),
    .empty   (EMPTY),
    .full    (FULL),
    .count   (COUNT),
    .overrun (overrun_evt)
  );

  assign FRAME_ERR  = frame_err_q;
  assign PARITY_ERR = parity_err_q;
  assign OVERRUN    = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo -- two receivers (no parity, even parity), CLKS_PER_BIT=16,
// FIFO_DEPTH=4. A queue-based model predicts FIFO contents and sticky flags
// from the frames the bench sends; outputs are compared on every negedge.
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int CPB   = 16;
  localparam int DB    = 8;
  localparam int DEPTH = 4;

  typedef enum int { EV_PUSH, EV_PERR, EV_FERR } ev_kind_t;
  typedef struct {
    int        cyc;
    int        dut;
    ev_kind_t  kind;
    logic [7:0] data;
  } ev_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       rxd     [2];
  logic       rd_en   [2];
  logic       err_clr [2];
  logic [7:0] rd_data [2];
  logic       empty   [2];
  logic       full    [2];
  logic [2:0] count   [2];
  logic       ferr    [2];
  logic       perr    [2];
  logic       ovr     [2];

  always #5 CLK = ~CLK;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(0), .FIFO_DEPTH(DEPTH)) dut_n (
    .CLK(CLK), .RST(RST), .RXD(rxd[0]), .RD_EN(rd_en[0]), .RD_DATA(rd_data[0]),
    .EMPTY(empty[0]), .FULL(full[0]), .COUNT(count[0]), .ERR_CLR(err_clr[0]),
    .FRAME_ERR(ferr[0]), .PARITY_ERR(perr[0]), .OVERRUN(ovr[0]));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB), .PARITY(2), .FIFO_DEPTH(DEPTH)) dut_e (
    .CLK(CLK), .RST(RST), .RXD(rxd[1]), .RD_EN(rd_en[1]), .RD_DATA(rd_data[1]),
    .EMPTY(empty[1]), .FULL(full[1]), .COUNT(count[1]), .ERR_CLR(err_clr[1]),
    .FRAME_ERR(ferr[1]), .PARITY_ERR(perr[1]), .OVERRUN(ovr[1]));

  // ---------------------------------------------------------------- model
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  bit         model_ready = 1'b0;
  ev_t        evq [$];
  logic [7:0] mq  [2][$];
  bit         m_ferr [2];
  bit         m_perr [2];
  bit         m_ovr  [2];

  function automatic int pmode(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Model step: one update per rising edge from the bench's own inputs.
  initial forever begin
    bit         pv [2];
    logic [7:0] pd [2];
    bit         pe [2];
    bit         fe [2];
    bit         rd_eff;
    bit         ov;
    @(posedge CLK);
    cyc++;
    if (RST) begin
      evq.delete();
      for (int d = 0; d < 2; d++) begin
        mq[d].delete();
        m_ferr[d] = 0; m_perr[d] = 0; m_ovr[d] = 0;
      end
      model_ready = 1'b1;
    end else begin
      for (int d = 0; d < 2; d++) begin
        pv[d] = 0; pd[d] = '0; pe[d] = 0; fe[d] = 0;
      end
      for (int i = 0; i < evq.size(); ) begin
        if (evq[i].cyc == cyc) begin
          case (evq[i].kind)
            EV_PUSH: begin pv[evq[i].dut] = 1; pd[evq[i].dut] = evq[i].data; end
            EV_PERR: pe[evq[i].dut] = 1;
            default: fe[evq[i].dut] = 1;
          endcase
          evq.delete(i);
        end else begin
          i++;
        end
      end
      for (int d = 0; d < 2; d++) begin
        rd_eff = rd_en[d] && (mq[d].size() > 0);
        ov     = 0;
        if (pv[d] && mq[d].size() == DEPTH && !rd_eff) begin
          ov = 1;
        end else begin
          if (rd_eff) void'(mq[d].pop_front());
          if (pv[d])  mq[d].push_back(pd[d]);
        end
        m_ferr[d] = fe[d] | (m_ferr[d] & !err_clr[d]);
        m_perr[d] = pe[d] | (m_perr[d] & !err_clr[d]);
        m_ovr[d]  = ov    | (m_ovr[d]  & !err_clr[d]);
      end
    end
  end

  // Compare process: every falling edge, both DUTs against the model.
  initial forever begin
    @(negedge CLK);
    if (model_ready) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("d%0d_empty", d), 32'(empty[d]), 32'(mq[d].size() == 0));
        check($sformatf("d%0d_full", d),  32'(full[d]),  32'(mq[d].size() == DEPTH));
        check($sformatf("d%0d_count", d), 32'(count[d]), 32'(mq[d].size()));
        if (mq[d].size() > 0)
          check($sformatf("d%0d_rd_data", d), 32'(rd_data[d]), 32'(mq[d][0]));
        check($sformatf("d%0d_frame_err", d),  32'(ferr[d]), 32'(m_ferr[d]));
        check($sformatf("d%0d_parity_err", d), 32'(perr[d]), 32'(m_perr[d]));
        check($sformatf("d%0d_overrun", d),    32'(ovr[d]),  32'(m_ovr[d]));
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  // Start edge driven after edge c; two synchronizer edges, one detect edge,
  // half a bit to the start centre, then one bit per data/parity/stop bit.
  function automatic int stop_cycle(input int c, input int d);
    return c + 3 + CPB / 2 + CPB * (DB + 1 + ((pmode(d) != 0) ? 1 : 0));
  endfunction

  task automatic hold_bit(input int d, input logic v);
    rxd[d] = v;
    repeat (CPB) @(negedge CLK);
  endtask

  task automatic send_frame(input int d, input logic [7:0] data,
                            input bit bad_par, input bit stop_val);
    int   c;
    int   sc;
    logic p;
    bit   has_par;
    has_par = (pmode(d) != 0);
    p       = (pmode(d) == 1) ? ~(^data) : (^data);
    if (bad_par) p = ~p;
    @(negedge CLK);
    c  = cyc;
    sc = stop_cycle(c, d);
    if (!stop_val)          evq.push_back('{cyc: sc, dut: d, kind: EV_FERR, data: 8'h00});
    if (has_par && bad_par) evq.push_back('{cyc: sc, dut: d, kind: EV_PERR, data: 8'h00});
    if (stop_val && !(has_par && bad_par))
      evq.push_back('{cyc: sc, dut: d, kind: EV_PUSH, data: data});
    hold_bit(d, 1'b0);
    for (int i = 0; i < DB; i++) hold_bit(d, data[i]);
    if (has_par) hold_bit(d, p);
    hold_bit(d, stop_val);
    rxd[d] = 1'b1;
  endtask

  task automatic pop_check(input int d, input logic [7:0] exp, input string name);
    check(name, 32'(rd_data[d]), 32'(exp));
    rd_en[d] = 1'b1;
    @(negedge CLK);
    rd_en[d] = 1'b0;
  endtask

  task automatic clear_errs(input int d);
    err_clr[d] = 1'b1;
    @(negedge CLK);
    err_clr[d] = 1'b0;
  endtask

  initial begin
    bit done;
    for (int d = 0; d < 2; d++) begin
      rxd[d] = 1'b1; rd_en[d] = 1'b0; err_clr[d] = 1'b0;
    end
    repeat (3) @(negedge CLK);
    check("reset_empty", 32'(empty[0]), 32'd1);
    check("reset_count", 32'(count[0]), 32'd0);
    check("reset_full",  32'(full[0]),  32'd0);
    check("reset_flags", {29'd0, ferr[1], perr[1], ovr[1]}, 32'd0);
    RST = 1'b0;
    repeat (CPB) @(negedge CLK);

    // Single frame, no parity.
    send_frame(0, 8'h41, 0, 1);
    check("single_empty", 32'(empty[0]), 32'd0);
    check("single_flags", {29'd0, ferr[0], perr[0], ovr[0]}, 32'd0);
    pop_check(0, 8'h41, "single_data");
    check("single_popped_empty", 32'(empty[0]), 32'd1);

    // Even parity: wrong parity bit discards the word.
    send_frame(1, 8'h41, 1, 1);
    check("par_err_set", 32'(perr[1]), 32'd1);
    check("par_err_empty", 32'(empty[1]), 32'd1);
    clear_errs(1);
    check("par_err_clr", 32'(perr[1]), 32'd0);
    send_frame(1, 8'hC3, 0, 1);
    pop_check(1, 8'hC3, "par_good_data");

    // Five frames into a four-deep FIFO.
    for (int i = 1; i <= 5; i++) send_frame(0, 8'(i), 0, 1);
    check("ovr_count", 32'(count[0]), 32'd4);
    check("ovr_full",  32'(full[0]),  32'd1);
    check("ovr_flag",  32'(ovr[0]),   32'd1);
    check("ovr_model_depth", 32'(mq[0].size()), 32'd4);
    for (int i = 1; i <= 4; i++) pop_check(0, 8'(i), $sformatf("ovr_read%0d", i));
    clear_errs(0);

    // Line held low for 20 bit times: framing error, then recovery.
    begin
      int c;
      @(negedge CLK);
      c = cyc;
      evq.push_back('{cyc: stop_cycle(c, 0), dut: 0, kind: EV_FERR, data: 8'h00});
      rxd[0] = 1'b0;
      repeat (20 * CPB) @(negedge CLK);
      rxd[0] = 1'b1;
    end
    check("break_ferr", 32'(ferr[0]), 32'd1);
    check("break_no_push", 32'(empty[0]), 32'd1);
    repeat (2 * CPB) @(negedge CLK);
    send_frame(0, 8'h55, 0, 1);
    pop_check(0, 8'h55, "break_recover_data");
    clear_errs(0);

    // Glitch, then reset in the middle of a frame with the line low.
    send_frame(0, 8'h77, 0, 1);
    rxd[0] = 1'b0;
    repeat (4) @(negedge CLK);
    rxd[0] = 1'b1;
    repeat (2 * CPB) @(negedge CLK);
    check("glitch_count", 32'(count[0]), 32'd1);
    hold_bit(0, 1'b0);                            // start of 8'hA5
    hold_bit(0, 1'b1); hold_bit(0, 1'b0); hold_bit(0, 1'b1);
    rxd[0] = 1'b0;                                // bit 3
    repeat (CPB / 2) @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    check("rst_count", 32'(count[0]), 32'd0);
    repeat (12 * CPB) @(negedge CLK);             // line still low after reset
    check("rst_no_start", 32'(ferr[0]), 32'd0);
    rxd[0] = 1'b1;
    repeat (2 * CPB) @(negedge CLK);
    send_frame(0, 8'h3C, 0, 1);
    pop_check(0, 8'h3C, "rst_next_data");

    // Randomized traffic with concurrent reads and error clears.
    for (int d = 0; d < 2; d++) begin
      done = 1'b0;
      fork
        begin
          bit stop_ok;
          bit bad_par;
          stop_ok = 1'b1;
          for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(2, 20) + (stop_ok ? 0 : CPB)) @(negedge CLK);
            stop_ok = ($urandom_range(0, 7) != 0);
            bad_par = (pmode(d) != 0) && ($urandom_range(0, 5) == 0);
            send_frame(d, 8'($urandom), bad_par, stop_ok);
          end
          repeat (2 * CPB) @(negedge CLK);
          done = 1'b1;
        end
        begin
          while (!done) begin
            @(negedge CLK);
            rd_en[d]   = ($urandom_range(0, 5) == 0);
            err_clr[d] = ($urandom_range(0, 63) == 0);
          end
          rd_en[d]   = 1'b0;
          err_clr[d] = 1'b0;
        end
      join
    end

    repeat (4) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
